// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 codes, FSM state type and byte-enable type for
//               the RV32 data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {INIT, IDLE} dmem_state_t;

    typedef logic [3:0] byte_en_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane
// Description : Combinational lane logic: store byte enables / data shift,
//               load extraction and extension, illegal/misaligned detection.
//               DMEM_MISALIGN_ERR_EN: misaligned H/W accesses flag an error
//               instead of being forced to natural alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output byte_en_t    be,
    output logic [31:0] wdata_sh,
    output logic [1:0]  eff_lane,
    output logic        err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic        illegal;
    logic        is_h;
    logic        is_w;
    logic [31:0] ld_shifted;

    always_comb begin
        if (we) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        is_h     = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w     = (funct3 == F3_W);
        eff_lane = lane;
`ifdef DMEM_MISALIGN_ERR_EN
        err = illegal || (is_h && lane[0]) || (is_w && (lane != 2'd0));
`else
        err = illegal;
        if (is_h) begin
            eff_lane[0] = 1'b0;
        end
        if (is_w) begin
            eff_lane = 2'd0;
        end
`endif
        case (funct3)
            F3_B:    be = byte_en_t'(4'b0001 << eff_lane);
            F3_H:    be = byte_en_t'(4'b0011 << eff_lane);
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        wdata_sh = wdata << {eff_lane, 3'b000};
    end

    always_comb begin
        ld_shifted = ld_word >> {ld_lane, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_W:    ld_data = ld_shifted;
            F3_BU:   ld_data = {24'd0, ld_shifted[7:0]};
            F3_HU:   ld_data = {16'd0, ld_shifted[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : RV32 data memory with valid/ready request port, registered
//               response and post-reset zero-clear sequencer.
//               DMEM_MISALIGN_ERR_EN (see dmem_lane) selects misalign handling.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int ADDR_W    = $clog2(DEPTH) + 2,
    parameter bit ZERO_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int                  IDX_W     = ADDR_W - 2;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam dmem_state_t         RST_STATE = ZERO_INIT ? INIT : IDLE;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      rd_word_q;

    dmem_state_t      state_q,     state_d;
    logic [IDX_W-1:0] cnt_q,       cnt_d;
    logic             init_done_q, init_done_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic             ld_ok_q,     ld_ok_d;
    logic [2:0]       ld_f3_q,     ld_f3_d;
    logic [1:0]       ld_lane_q,   ld_lane_d;

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             st_we;
    logic             init_we;
    byte_en_t         be;
    logic [31:0]      wdata_sh;
    logic [1:0]       eff_lane;
    logic             lane_err;
    logic [31:0]      ld_data;

    dmem_lane u_lane (
        .we        (req_we),
        .funct3    (req_funct3),
        .lane      (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .eff_lane  (eff_lane),
        .err       (lane_err),
        .ld_funct3 (ld_f3_q),
        .ld_lane   (ld_lane_q),
        .ld_word   (rd_word_q),
        .ld_data   (ld_data)
    );

    assign idx       = req_addr[ADDR_W-1:2];
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    // A store coinciding with rst is dropped; INIT will clear memory anyway.
    assign st_we     = accept && req_we && !lane_err && !rst;
    assign init_we   = (state_q == INIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        ld_ok_d     = ld_ok_q;
        ld_f3_d     = ld_f3_q;
        ld_lane_d   = ld_lane_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: init_done_d = 1'b1;
        endcase
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = lane_err;
            ld_ok_d     = !req_we && !lane_err;
            ld_f3_d     = req_funct3;
            ld_lane_d   = eff_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_ok_q     <= 1'b0;
            ld_f3_q     <= F3_W;
            ld_lane_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_ok_q     <= ld_ok_d;
            ld_f3_q     <= ld_f3_d;
            ld_lane_q   <= ld_lane_d;
        end
    end

    // Storage has no reset; the INIT sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[cnt_q] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
        if (accept) begin
            rd_word_q <= mem_q[idx];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;
    assign rsp_rdata = ld_ok_q ? ld_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem
// Description : Self-checking bench for data_mem (DEPTH=16) against a
//               byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH) + 2;
    localparam int NBYTES = DEPTH * 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mm [NBYTES];
    logic [31:0] last_rd;
    logic        last_err;

    data_mem #(
        .DEPTH     (DEPTH),
        .ZERO_INIT (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
    endtask

    // Byte-addressed reference: size from funct3, little-endian bytes.
    task automatic model_op(input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          size;
        int          a;
        bit          legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a     = int'(addr);
`ifdef DMEM_MISALIGN_ERR_EN
        err = !legal || (a % size != 0);
`else
        err = !legal;
        a   = a - (a % size);
`endif
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mm[a+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mm[a+i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
                rd = v;
            end
        end
    endtask

    // Presents one request, leaves req_valid high so calls chain back-to-back.
    task automatic issue(input string tag, input bit we, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                         output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        model_op(we, f3, addr, wd, exp_rd, exp_err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
        chk({tag, "_rdata"}, rsp_rdata,      exp_rd);
        got      = rsp_rdata;
        last_rd  = exp_rd;
        last_err = exp_err;
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_hold_rdata"}, rsp_rdata, last_rd);
        chk({tag, "_idle_hold_err"}, 32'(rsp_err), 32'(last_err));
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_init_cycles"}, 32'(n), 32'd16);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [2:0]  f3;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        last_rd    = 32'd0;
        last_err   = 1'b0;
        model_clear();

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        wait_init("boot");

        for (int w = 0; w < DEPTH; w++) issue("lw_zero", 1'b0, 3'b010, ADDR_W'(w * 4), 32'd0, got);
        idle("lw_zero");

        issue("sw_beef", 1'b1, 3'b010, 6'h08, 32'hDEADBEEF, got);
        chk("sw_beef_rdata0", got, 32'd0);
        issue("lb_8", 1'b0, 3'b000, 6'h08, 32'd0, got);
        chk("lb_8_plan", got, 32'hFFFFFFEF);
        issue("lbu_b", 1'b0, 3'b100, 6'h0B, 32'd0, got);
        chk("lbu_b_plan", got, 32'h000000DE);
        issue("lh_a", 1'b0, 3'b001, 6'h0A, 32'd0, got);
        chk("lh_a_plan", got, 32'hFFFFDEAD);
        issue("lhu_a", 1'b0, 3'b101, 6'h0A, 32'd0, got);
        chk("lhu_a_plan", got, 32'h0000DEAD);
        idle("ext");

        issue("sw_w1", 1'b1, 3'b010, 6'h04, 32'h11223344, got);
        issue("sb_5", 1'b1, 3'b000, 6'h05, 32'hFFFFFF55, got);
        issue("lw_4", 1'b0, 3'b010, 6'h04, 32'd0, got);
        chk("lw_4_plan", got, 32'h11225544);
        idle("b2b");

        issue("lw_ill", 1'b0, 3'b011, 6'h00, 32'd0, got);
        chk("lw_ill_err", 32'(rsp_err), 32'd1);
        issue("sw_ill", 1'b1, 3'b100, 6'h00, 32'hFFFFFFFF, got);
        issue("lw_0", 1'b0, 3'b010, 6'h00, 32'd0, got);
        chk("lw_0_plan", got, 32'd0);
        idle("illegal");

        issue("sh_3", 1'b1, 3'b001, 6'h03, 32'h0000ABCD, got);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("sh_3_err", 32'(rsp_err), 32'd1);
        issue("lw_0_sh", 1'b0, 3'b010, 6'h00, 32'd0, got);
        chk("lw_0_sh_plan", got, 32'd0);
`else
        chk("sh_3_err", 32'(rsp_err), 32'd0);
        issue("lw_0_sh", 1'b0, 3'b010, 6'h00, 32'd0, got);
        chk("lw_0_sh_plan", got, 32'hABCD0000);
`endif
        idle("misalign");

        for (int i = 0; i < 400; i++) begin
            f3 = 3'($urandom_range(0, 7));
            issue("rand", 1'($urandom_range(0, 1)), f3, ADDR_W'($urandom_range(0, NBYTES - 1)),
                  $urandom, got);
            if ($urandom_range(0, 7) == 0) idle("rand");
        end
        idle("rand_end");

        issue("sw_pre", 1'b1, 3'b010, 6'h10, 32'hCAFEF00D, got);
        issue("lw_pre", 1'b0, 3'b010, 6'h10, 32'd0, got);
        chk("lw_pre_plan", got, 32'hCAFEF00D);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 6'h10;
        rst        = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        model_clear();
        last_rd   = 32'd0;
        last_err  = 1'b0;
        wait_init("reinit");
        issue("lw_post_10", 1'b0, 3'b010, 6'h10, 32'd0, got);
        chk("lw_post_10_plan", got, 32'd0);
        issue("lw_post_8", 1'b0, 3'b010, 6'h08, 32'd0, got);
        chk("lw_post_8_plan", got, 32'd0);
        for (int w = 0; w < DEPTH; w++) issue("lw_post", 1'b0, 3'b010, ADDR_W'(w * 4), 32'd0, got);
        idle("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
